sdram_qos_arbiter: RTL and testbench

SDRAM_QOS_ARBITER -- requirements
Module: sdram_qos_arbiter

---
 rtl/sdram_arb_pkg.sv | 24 ++
 rtl/sdram_qos_arbiter.sv | 248 ++++++++++++++++++++++++
 tb/tb_sdram_qos_arbiter.sv | 363 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sdram_arb_pkg.sv
// Shared types for the three-port SDRAM QoS arbiter: FSM states, requester
// indices and the default starvation threshold.
package sdram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        RESP = 2'd2
    } arb_state_e;

    typedef enum logic [1:0] {
        PORT_VID = 2'd0,
        PORT_CPU = 2'd1,
        PORT_DMA = 2'd2
    } port_e;

    localparam int STARVE_LIMIT_DEFAULT = 64;

    // Round-robin hands preference to the partner of whichever of cpu/dma just won.
    function automatic port_e rr_next(input port_e granted);
        return (granted == PORT_CPU) ? PORT_DMA : PORT_CPU;
    endfunction

endpackage

// File: rtl/sdram_qos_arbiter.sv
// Three-requester SDRAM arbiter: video has priority, cpu/dma share round-robin,
// starvation counters force a waiting cpu/dma ahead. One transaction in flight.
module sdram_qos_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEFAULT,
    parameter int ADDR_W       = 24
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              vid_cmd_valid,
    output logic              vid_cmd_ready,
    input  logic [ADDR_W-1:0] vid_addr_x16,
    input  logic              vid_burst,
    output logic              vid_resp_valid,
    output logic              vid_resp_last,
    output logic [15:0]       vid_rdata,
    input  logic              cpu_cmd_valid,
    output logic              cpu_cmd_ready,
    input  logic [ADDR_W-1:0] cpu_addr_x16,
    input  logic              cpu_burst,
    input  logic              cpu_wr,
    input  logic [15:0]       cpu_wdata,
    input  logic [1:0]        cpu_wmask,
    output logic              cpu_resp_valid,
    output logic              cpu_resp_last,
    output logic [15:0]       cpu_rdata,
    input  logic              dma_cmd_valid,
    output logic              dma_cmd_ready,
    input  logic [ADDR_W-1:0] dma_addr_x16,
    input  logic              dma_burst,
    input  logic              dma_wr,
    input  logic [15:0]       dma_wdata,
    input  logic [1:0]        dma_wmask,
    output logic              dma_resp_valid,
    output logic              dma_resp_last,
    output logic [15:0]       dma_rdata,
    output logic              sdram_cmd_valid,
    input  logic              sdram_cmd_ready,
    output logic              sdram_rd,
    output logic              sdram_wr,
    output logic [ADDR_W-1:0] sdram_addr_x16,
    output logic [15:0]       sdram_wdata,
    output logic [1:0]        sdram_wmask,
    output logic              sdram_burst,
    input  logic              sdram_resp_valid,
    input  logic              sdram_resp_last,
    input  logic [15:0]       sdram_rdata,
    output logic              err_o
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(STARVE_LIMIT);
    localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

    arb_state_e        state_r;
    port_e             owner_r;
    port_e             pref_r;
    logic              burst_r;
    logic              err_r;
    logic [CNT_W-1:0]  cpu_starve_r;
    logic [CNT_W-1:0]  dma_starve_r;

    logic              any_valid_s;
    logic              cpu_forced_s;
    logic              dma_forced_s;
    port_e             grant_s;
    logic              own_valid_s;
    logic              own_wr_s;
    logic [ADDR_W-1:0] own_addr_s;
    logic [15:0]       own_wdata_s;
    logic [1:0]        own_wmask_s;
    logic              own_burst_s;
    logic              in_cmd_s;
    logic              in_resp_s;
    logic              resp_route_s;
    logic              resp_last_s;
    logic              cpu_other_s;
    logic              dma_other_s;
    logic              cpu_win_s;
    logic              dma_win_s;

    // Arbitration: saturated starve counters beat video, video beats round-robin.
    always_comb begin
        any_valid_s  = vid_cmd_valid || cpu_cmd_valid || dma_cmd_valid;
        cpu_forced_s = cpu_cmd_valid && (cpu_starve_r >= LIMIT_C);
        dma_forced_s = dma_cmd_valid && (dma_starve_r >= LIMIT_C);
        if (cpu_forced_s && dma_forced_s) begin
            grant_s = pref_r;
        end else if (cpu_forced_s) begin
            grant_s = PORT_CPU;
        end else if (dma_forced_s) begin
            grant_s = PORT_DMA;
        end else if (vid_cmd_valid) begin
            grant_s = PORT_VID;
        end else if (cpu_cmd_valid && dma_cmd_valid) begin
            grant_s = pref_r;
        end else if (cpu_cmd_valid) begin
            grant_s = PORT_CPU;
        end else begin
            grant_s = PORT_DMA;
        end
    end

    // Owner's command fields, muxed straight through to the SDRAM side.
    always_comb begin
        own_valid_s = 1'b0;
        own_wr_s    = 1'b0;
        own_addr_s  = '0;
        own_wdata_s = 16'h0000;
        own_wmask_s = 2'b00;
        own_burst_s = 1'b0;
        case (owner_r)
            PORT_VID: begin
                own_valid_s = vid_cmd_valid;
                own_addr_s  = vid_addr_x16;
                own_burst_s = vid_burst;
            end
            PORT_CPU: begin
                own_valid_s = cpu_cmd_valid;
                own_wr_s    = cpu_wr;
                own_addr_s  = cpu_addr_x16;
                own_wdata_s = cpu_wdata;
                own_wmask_s = cpu_wmask;
                own_burst_s = cpu_burst;
            end
            PORT_DMA: begin
                own_valid_s = dma_cmd_valid;
                own_wr_s    = dma_wr;
                own_addr_s  = dma_addr_x16;
                own_wdata_s = dma_wdata;
                own_wmask_s = dma_wmask;
                own_burst_s = dma_burst;
            end
            default: begin
                own_valid_s = 1'b0;
            end
        endcase
    end

    assign in_cmd_s     = (state_r == CMD);
    assign in_resp_s    = (state_r == RESP);
    assign resp_route_s = in_resp_s && sdram_resp_valid;
    assign resp_last_s  = burst_r ? sdram_resp_last : 1'b1;

    assign sdram_cmd_valid = in_cmd_s && own_valid_s;
    assign sdram_rd        = in_cmd_s && !own_wr_s;
    assign sdram_wr        = in_cmd_s && own_wr_s;
    assign sdram_addr_x16  = in_cmd_s ? own_addr_s : '0;
    assign sdram_wdata     = in_cmd_s ? own_wdata_s : 16'h0000;
    assign sdram_wmask     = in_cmd_s ? own_wmask_s : 2'b00;
    assign sdram_burst     = in_cmd_s && own_burst_s;

    assign vid_cmd_ready = in_cmd_s && (owner_r == PORT_VID) && sdram_cmd_ready;
    assign cpu_cmd_ready = in_cmd_s && (owner_r == PORT_CPU) && sdram_cmd_ready;
    assign dma_cmd_ready = in_cmd_s && (owner_r == PORT_DMA) && sdram_cmd_ready;

    assign vid_resp_valid = resp_route_s && (owner_r == PORT_VID);
    assign cpu_resp_valid = resp_route_s && (owner_r == PORT_CPU);
    assign dma_resp_valid = resp_route_s && (owner_r == PORT_DMA);
    assign vid_resp_last  = vid_resp_valid && resp_last_s;
    assign cpu_resp_last  = cpu_resp_valid && resp_last_s;
    assign dma_resp_last  = dma_resp_valid && resp_last_s;
    assign vid_rdata      = vid_resp_valid ? sdram_rdata : 16'h0000;
    assign cpu_rdata      = cpu_resp_valid ? sdram_rdata : 16'h0000;
    assign dma_rdata      = dma_resp_valid ? sdram_rdata : 16'h0000;

    assign err_o = err_r;

    // Transaction FSM: latch owner in IDLE, issue in CMD, collect data in RESP.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_r <= IDLE;
            owner_r <= PORT_VID;
            pref_r  <= PORT_CPU;
            burst_r <= 1'b0;
            err_r   <= 1'b0;
        end else begin
            if (sdram_resp_valid && !in_resp_s) begin
                err_r <= 1'b1;
            end
            case (state_r)
                IDLE: begin
                    if (any_valid_s) begin
                        owner_r <= grant_s;
                        state_r <= CMD;
                        if (grant_s != PORT_VID) begin
                            pref_r <= rr_next(grant_s);
                        end
                    end
                end
                CMD: begin
                    if (!own_valid_s) begin
                        state_r <= IDLE;
                    end else if (sdram_cmd_ready) begin
                        if (own_wr_s) begin
                            state_r <= IDLE;
                        end else begin
                            burst_r <= own_burst_s;
                            state_r <= RESP;
                        end
                    end
                end
                RESP: begin
                    if (sdram_resp_valid && (sdram_resp_last || !burst_r)) begin
                        state_r <= IDLE;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    // A waiting port "loses" a cycle whenever someone else holds or wins the grant.
    always_comb begin
        if (state_r == IDLE) begin
            cpu_other_s = any_valid_s && (grant_s != PORT_CPU);
            dma_other_s = any_valid_s && (grant_s != PORT_DMA);
        end else begin
            cpu_other_s = (owner_r != PORT_CPU);
            dma_other_s = (owner_r != PORT_DMA);
        end
        cpu_win_s = (state_r == IDLE) && any_valid_s && (grant_s == PORT_CPU);
        dma_win_s = (state_r == IDLE) && any_valid_s && (grant_s == PORT_DMA);
    end

    // Saturating starvation counters for cpu and dma.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cpu_starve_r <= '0;
            dma_starve_r <= '0;
        end else begin
            if (cpu_win_s) begin
                cpu_starve_r <= '0;
            end else if (cpu_cmd_valid && cpu_other_s && (cpu_starve_r < LIMIT_C)) begin
                cpu_starve_r <= cpu_starve_r + ONE_C;
            end
            if (dma_win_s) begin
                dma_starve_r <= '0;
            end else if (dma_cmd_valid && dma_other_s && (dma_starve_r < LIMIT_C)) begin
                dma_starve_r <= dma_starve_r + ONE_C;
            end
        end
    end

endmodule

// File: tb/tb_sdram_qos_arbiter.sv
// Bench for sdram_qos_arbiter: directed scenarios plus randomized traffic,
// all checked against a transaction-level arbitration model.
module tb_sdram_qos_arbiter;
    import sdram_arb_pkg::*;

    localparam int AW  = 24;
    localparam int LIM = 4;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic          burst;
        logic          wr;
        logic [15:0]   wdata;
        logic [1:0]    wmask;
    } req_t;

    typedef struct packed {
        logic [1:0] port;
        req_t       r;
    } grant_t;

    logic          clk_i = 1'b0;
    logic          rst_n_i;
    logic          vid_cmd_valid, vid_cmd_ready, vid_burst, vid_resp_valid, vid_resp_last;
    logic [AW-1:0] vid_addr_x16;
    logic [15:0]   vid_rdata;
    logic          cpu_cmd_valid, cpu_cmd_ready, cpu_burst, cpu_wr, cpu_resp_valid, cpu_resp_last;
    logic [AW-1:0] cpu_addr_x16;
    logic [15:0]   cpu_wdata, cpu_rdata;
    logic [1:0]    cpu_wmask;
    logic          dma_cmd_valid, dma_cmd_ready, dma_burst, dma_wr, dma_resp_valid, dma_resp_last;
    logic [AW-1:0] dma_addr_x16;
    logic [15:0]   dma_wdata, dma_rdata;
    logic [1:0]    dma_wmask;
    logic          sdram_cmd_valid, sdram_cmd_ready, sdram_rd, sdram_wr, sdram_burst;
    logic [AW-1:0] sdram_addr_x16;
    logic [15:0]   sdram_wdata, sdram_rdata;
    logic [1:0]    sdram_wmask;
    logic          sdram_resp_valid, sdram_resp_last;
    logic          err_o;

    logic [2:0]    cmd_ready_v, resp_valid_v, resp_last_v;
    logic [15:0]   rdata_v [3];

    assign cmd_ready_v  = {dma_cmd_ready, cpu_cmd_ready, vid_cmd_ready};
    assign resp_valid_v = {dma_resp_valid, cpu_resp_valid, vid_resp_valid};
    assign resp_last_v  = {dma_resp_last, cpu_resp_last, vid_resp_last};
    assign rdata_v[0]   = vid_rdata;
    assign rdata_v[1]   = cpu_rdata;
    assign rdata_v[2]   = dma_rdata;

    sdram_qos_arbiter #(.STARVE_LIMIT(LIM), .ADDR_W(AW)) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i),
        .vid_cmd_valid(vid_cmd_valid), .vid_cmd_ready(vid_cmd_ready), .vid_addr_x16(vid_addr_x16),
        .vid_burst(vid_burst), .vid_resp_valid(vid_resp_valid), .vid_resp_last(vid_resp_last),
        .vid_rdata(vid_rdata),
        .cpu_cmd_valid(cpu_cmd_valid), .cpu_cmd_ready(cpu_cmd_ready), .cpu_addr_x16(cpu_addr_x16),
        .cpu_burst(cpu_burst), .cpu_wr(cpu_wr), .cpu_wdata(cpu_wdata), .cpu_wmask(cpu_wmask),
        .cpu_resp_valid(cpu_resp_valid), .cpu_resp_last(cpu_resp_last), .cpu_rdata(cpu_rdata),
        .dma_cmd_valid(dma_cmd_valid), .dma_cmd_ready(dma_cmd_ready), .dma_addr_x16(dma_addr_x16),
        .dma_burst(dma_burst), .dma_wr(dma_wr), .dma_wdata(dma_wdata), .dma_wmask(dma_wmask),
        .dma_resp_valid(dma_resp_valid), .dma_resp_last(dma_resp_last), .dma_rdata(dma_rdata),
        .sdram_cmd_valid(sdram_cmd_valid), .sdram_cmd_ready(sdram_cmd_ready), .sdram_rd(sdram_rd),
        .sdram_wr(sdram_wr), .sdram_addr_x16(sdram_addr_x16), .sdram_wdata(sdram_wdata),
        .sdram_wmask(sdram_wmask), .sdram_burst(sdram_burst), .sdram_resp_valid(sdram_resp_valid),
        .sdram_resp_last(sdram_resp_last), .sdram_rdata(sdram_rdata), .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    int       passes = 0;
    int       total  = 0;
    req_t     req_q [3];
    bit       has_req [3];
    int       gen_mode [3];   // 0 none, 1 random mix, 2 back-to-back bursts, 3 back-to-back singles
    int       rdy_mode;       // 0 random ready, 1 always ready
    logic [AW-1:0] vid_next_addr;
    int       m_owner, m_left, m_pref;
    bit       m_burst;
    int       m_wait [3];
    grant_t   glog [$];
    int       words_seen, wr_cycles;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic drive_ports();
        vid_cmd_valid = has_req[0]; vid_addr_x16 = req_q[0].addr; vid_burst = req_q[0].burst;
        cpu_cmd_valid = has_req[1]; cpu_addr_x16 = req_q[1].addr; cpu_burst = req_q[1].burst;
        cpu_wr = req_q[1].wr; cpu_wdata = req_q[1].wdata; cpu_wmask = req_q[1].wmask;
        dma_cmd_valid = has_req[2]; dma_addr_x16 = req_q[2].addr; dma_burst = req_q[2].burst;
        dma_wr = req_q[2].wr; dma_wdata = req_q[2].wdata; dma_wmask = req_q[2].wmask;
    endtask

    task automatic model_reset();
        m_owner = -1; m_left = 0; m_pref = 1; m_burst = 1'b0;
        for (int p = 0; p < 3; p++) m_wait[p] = 0;
        glog.delete();
        words_seen = 0; wr_cycles = 0;
    endtask

    task automatic do_reset();
        rst_n_i = 1'b0;
        for (int p = 0; p < 3; p++) begin has_req[p] = 1'b0; gen_mode[p] = 0; end
        drive_ports();
        sdram_cmd_ready = 1'b0; sdram_resp_valid = 1'b0; sdram_resp_last = 1'b0; sdram_rdata = 16'h0000;
        repeat (2) @(posedge clk_i);
        #1;
        rst_n_i = 1'b1;
        model_reset();
    endtask

    task automatic new_req(input int p);
        case (gen_mode[p])
            1: if ($urandom_range(0, 3) == 0) begin
                has_req[p] = 1'b1;
                req_q[p].addr  = AW'($urandom);
                req_q[p].wr    = (p != 0) && ($urandom_range(0, 2) == 0);
                req_q[p].burst = !req_q[p].wr && 1'($urandom_range(0, 1));
                req_q[p].wdata = 16'($urandom);
                req_q[p].wmask = 2'($urandom);
            end
            2: begin
                has_req[p] = 1'b1;
                req_q[p] = '{addr: vid_next_addr, burst: 1'b1, wr: 1'b0, wdata: 16'h0000, wmask: 2'b00};
                vid_next_addr = vid_next_addr + 24'd8;
            end
            3: begin
                has_req[p] = 1'b1;
                req_q[p] = '{addr: AW'($urandom), burst: 1'b0, wr: 1'b0, wdata: 16'h0000, wmask: 2'b00};
            end
            default: ;
        endcase
    endtask

    // Spec arbitration rule: starved cpu/dma first, then video, then round-robin.
    function automatic int model_pick();
        bit cf, df;
        int w;
        cf = has_req[1] && (m_wait[1] >= LIM);
        df = has_req[2] && (m_wait[2] >= LIM);
        if (cf && df) w = m_pref;
        else if (cf) w = 1;
        else if (df) w = 2;
        else if (has_req[0]) w = 0;
        else if (has_req[1] && has_req[2]) w = m_pref;
        else if (has_req[1]) w = 1;
        else w = 2;
        if (w != 0) begin
            m_pref = (w == 1) ? 2 : 1;
            m_wait[w] = 0;
        end
        return w;
    endfunction

    task automatic check_cycle();
        int   cur;
        bit   idle;
        req_t r;
        idle = (m_owner < 0);
        cur  = m_owner;
        if (idle && (has_req[0] || has_req[1] || has_req[2])) cur = model_pick();
        for (int p = 1; p < 3; p++)
            if (has_req[p] && cur >= 0 && cur != p && m_wait[p] < LIM) m_wait[p]++;
        if (sdram_wr === 1'b1) wr_cycles++;
        for (int p = 0; p < 3; p++) begin
            if (p != m_owner) begin
                chk("nonowner_ready", cmd_ready_v[p], 32'd0);
                chk("nonowner_resp", resp_valid_v[p], 32'd0);
            end
        end
        if (idle) begin
            chk("idle_cmd_valid", sdram_cmd_valid, 32'd0);
            chk("idle_rd_wr", {sdram_rd, sdram_wr}, 32'd0);
            if (cur >= 0) begin
                m_owner = cur;
                m_left  = 0;
                glog.push_back('{port: 2'(cur), r: req_q[cur]});
            end
        end else if (m_left == 0) begin
            r = req_q[m_owner];
            chk("cmd_valid", sdram_cmd_valid, 32'd1);
            chk("cmd_addr", sdram_addr_x16, r.addr);
            chk("cmd_rd", sdram_rd, !r.wr);
            chk("cmd_wr", sdram_wr, r.wr);
            chk("cmd_burst", sdram_burst, r.burst);
            if (r.wr) begin
                chk("cmd_wdata", sdram_wdata, r.wdata);
                chk("cmd_wmask", sdram_wmask, r.wmask);
            end
            chk("owner_ready", cmd_ready_v[m_owner], sdram_cmd_ready);
            if (sdram_cmd_ready) begin
                has_req[m_owner] = 1'b0;
                if (r.wr) begin
                    m_owner = -1;
                end else begin
                    m_left  = r.burst ? 8 : 1;
                    m_burst = r.burst;
                end
            end
        end else begin
            chk("owner_resp_valid", resp_valid_v[m_owner], sdram_resp_valid);
            if (sdram_resp_valid) begin
                chk("owner_rdata", rdata_v[m_owner], sdram_rdata);
                chk("owner_last", resp_last_v[m_owner], m_burst ? sdram_resp_last : 1'b1);
                words_seen++;
                m_left--;
                if (m_left == 0) m_owner = -1;
            end
        end
    endtask

    task automatic run(input int cycles, input int stop_words);
        int w0;
        w0 = words_seen;
        for (int c = 0; c < cycles; c++) begin
            @(posedge clk_i);
            #1;
            for (int p = 0; p < 3; p++) if (!has_req[p]) new_req(p);
            drive_ports();
            sdram_cmd_ready = (rdy_mode == 1) ? 1'b1 : 1'($urandom_range(0, 1));
            if (m_owner >= 0 && m_left > 0 && $urandom_range(0, 3) != 0) begin
                sdram_resp_valid = 1'b1;
                sdram_rdata      = 16'($urandom);
                sdram_resp_last  = m_burst ? (m_left == 1) : 1'b0;
            end else begin
                sdram_resp_valid = 1'b0;
                sdram_rdata      = 16'h0000;
                sdram_resp_last  = 1'b0;
            end
            #1;
            check_cycle();
            if (stop_words > 0 && (words_seen - w0) >= stop_words) break;
        end
    endtask

    initial begin
        for (int p = 0; p < 3; p++) begin req_q[p] = '0; has_req[p] = 1'b0; gen_mode[p] = 0; end
        rdy_mode = 1;
        vid_next_addr = 24'h001000;
        model_reset();

        // Reset with live inputs: everything quiet.
        rst_n_i = 1'b0;
        has_req[0] = 1'b1; req_q[0].addr = 24'h00ABCD;
        drive_ports();
        sdram_cmd_ready = 1'b1; sdram_resp_valid = 1'b1; sdram_resp_last = 1'b1; sdram_rdata = 16'h5A5A;
        repeat (2) @(posedge clk_i);
        #1;
        chk("rst_cmd_valid", sdram_cmd_valid, 32'd0);
        chk("rst_rd_wr", {sdram_rd, sdram_wr}, 32'd0);
        chk("rst_addr", sdram_addr_x16, 32'd0);
        chk("rst_wdata_mask_burst", {sdram_wdata, sdram_wmask, sdram_burst}, 32'd0);
        chk("rst_cmd_ready", cmd_ready_v, 32'd0);
        chk("rst_resp_valid", resp_valid_v, 32'd0);
        chk("rst_resp_last", resp_last_v, 32'd0);
        chk("rst_rdata", vid_rdata, 32'd0);
        chk("rst_err", err_o, 32'd0);
        do_reset();

        // Simultaneous reads: vid, cpu, dma in order.
        rdy_mode = 1;
        has_req[0] = 1'b1; req_q[0] = '{addr: 24'h000100, burst: 1'b0, wr: 1'b0, wdata: 16'h0, wmask: 2'b0};
        has_req[1] = 1'b1; req_q[1] = '{addr: 24'h000200, burst: 1'b0, wr: 1'b0, wdata: 16'h0, wmask: 2'b0};
        has_req[2] = 1'b1; req_q[2] = '{addr: 24'h000300, burst: 1'b0, wr: 1'b0, wdata: 16'h0, wmask: 2'b0};
        run(40, 0);
        chk("order_count", glog.size(), 32'd3);
        chk("order_0", glog[0].port, 32'd0);
        chk("order_1", glog[1].port, 32'd1);
        chk("order_2", glog[2].port, 32'd2);
        chk("order_addr_0", glog[0].r.addr, 32'h000100);
        chk("order_addr_1", glog[1].r.addr, 32'h000200);
        chk("order_addr_2", glog[2].r.addr, 32'h000300);

        // cpu and dma hammering single reads alternate.
        do_reset();
        gen_mode[1] = 3; gen_mode[2] = 3;
        run(60, 0);
        chk("rr_count_ok", glog.size() >= 4, 32'd1);
        chk("rr_0", glog[0].port, 32'd1);
        chk("rr_1", glog[1].port, 32'd2);
        chk("rr_2", glog[2].port, 32'd1);
        chk("rr_3", glog[3].port, 32'd2);

        // Video bursts back to back cannot starve a waiting cpu.
        do_reset();
        gen_mode[0] = 2;
        has_req[1] = 1'b1; req_q[1] = '{addr: 24'h000ABC, burst: 1'b0, wr: 1'b0, wdata: 16'h0, wmask: 2'b0};
        run(80, 0);
        chk("starve_count_ok", glog.size() >= 3, 32'd1);
        chk("starve_0_vid", glog[0].port, 32'd0);
        chk("starve_0_burst", glog[0].r.burst, 32'd1);
        chk("starve_1_cpu", glog[1].port, 32'd1);
        chk("starve_1_addr", glog[1].r.addr, 32'h000ABC);
        chk("starve_2_vid", glog[2].port, 32'd0);

        // Single dma write.
        do_reset();
        has_req[2] = 1'b1; req_q[2] = '{addr: 24'h000010, burst: 1'b0, wr: 1'b1, wdata: 16'hBEEF, wmask: 2'b01};
        run(6, 0);
        chk("wr_grants", glog.size(), 32'd1);
        chk("wr_port", glog[0].port, 32'd2);
        chk("wr_cycles", wr_cycles, 32'd1);
        chk("wr_no_resp", words_seen, 32'd0);

        // Reset in the middle of a video burst.
        do_reset();
        has_req[0] = 1'b1; req_q[0] = '{addr: 24'h000400, burst: 1'b1, wr: 1'b0, wdata: 16'h0, wmask: 2'b0};
        run(60, 3);
        chk("midrst_words", words_seen, 32'd3);
        @(posedge clk_i);
        #1;
        sdram_resp_valid = 1'b1; sdram_resp_last = 1'b0; sdram_rdata = 16'h1234;
        #1;
        chk("midrst_live", vid_resp_valid, 32'd1);
        rst_n_i = 1'b0;
        #1;
        chk("midrst_resp", resp_valid_v, 32'd0);
        chk("midrst_rdata", vid_rdata, 32'd0);
        chk("midrst_last", resp_last_v, 32'd0);
        chk("midrst_cmd", {sdram_cmd_valid, sdram_rd, sdram_wr}, 32'd0);
        chk("midrst_err", err_o, 32'd0);
        do_reset();
        has_req[1] = 1'b1; req_q[1] = '{addr: 24'h000555, burst: 1'b0, wr: 1'b0, wdata: 16'h0, wmask: 2'b0};
        run(20, 0);
        chk("postrst_grants", glog.size(), 32'd1);
        chk("postrst_port", glog[0].port, 32'd1);
        chk("postrst_words", words_seen, 32'd1);
        chk("postrst_err", err_o, 32'd0);

        // Stray response while idle is dropped and latches err_o.
        do_reset();
        sdram_resp_valid = 1'b1; sdram_resp_last = 1'b1; sdram_rdata = 16'hDEAD;
        #1;
        chk("stray_dropped", resp_valid_v, 32'd0);
        chk("stray_err_pre", err_o, 32'd0);
        @(posedge clk_i);
        #1;
        sdram_resp_valid = 1'b0;
        chk("stray_err_set", err_o, 32'd1);
        repeat (5) @(posedge clk_i);
        #1;
        chk("stray_err_sticky", err_o, 32'd1);
        rst_n_i = 1'b0;
        #1;
        chk("stray_err_cleared", err_o, 32'd0);

        // Randomized mixed traffic against the model.
        do_reset();
        rdy_mode = 0;
        gen_mode[0] = 1; gen_mode[1] = 1; gen_mode[2] = 1;
        run(3000, 0);
        chk("rand_progress", glog.size() >= 50, 32'd1);
        chk("rand_err", err_o, 32'd0);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
